// File: rtl/tmds_encoder_3ch.sv
// rtl/tmds_encoder_3ch.sv - three-channel TMDS (DVI) symbol encoder, two-stage pipeline per channel
// Each lane minimises transitions in stage 1 and balances DC disparity in stage 2.

module tmds_encoder_3ch_lane #(
  parameter logic [1:0] RST_CODE_SEL = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       de_s1,
  input  logic [7:0] data,
  input  logic [1:0] ctrl,
  output logic [9:0] raw
);

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  logic [3:0]        n1_d;
  logic              use_xnor;
  logic [8:0]        qm_d;
  logic [8:0]        qm;
  logic [1:0]        ctrl_s1;
  logic [3:0]        n1_q;
  logic signed [5:0] diff;
  logic signed [5:0] cnt;
  logic signed [5:0] cnt_d;
  logic [9:0]        raw_d;

  always_comb begin
    n1_d = 4'd0;
    for (int i = 0; i < 8; i++) n1_d = n1_d + {3'b000, data[i]};
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data[0]);
    qm_d    = '0;
    qm_d[0] = data[0];
    for (int i = 1; i < 8; i++)
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ data[i]) : (qm_d[i-1] ^ data[i]);
    qm_d[8] = ~use_xnor;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qm      <= '0;
      ctrl_s1 <= '0;
    end else begin
      qm      <= qm_d;
      ctrl_s1 <= ctrl;
    end
  end

  // diff = N1 - N0 of the stage-1 word; cnt is the running 10-bit symbol disparity
  always_comb begin
    n1_q = 4'd0;
    for (int i = 0; i < 8; i++) n1_q = n1_q + {3'b000, qm[i]};
    diff  = $signed({1'b0, n1_q, 1'b0}) - 6'sd8;
    raw_d = ctrl_code(ctrl_s1);
    cnt_d = '0;
    if (de_s1) begin
      if (cnt == 6'sd0 || diff == 6'sd0) begin
        raw_d = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        cnt_d = qm[8] ? (cnt + diff) : (cnt - diff);
      end else if ((cnt > 6'sd0 && diff > 6'sd0) || (cnt < 6'sd0 && diff < 6'sd0)) begin
        raw_d = {1'b1, qm[8], ~qm[7:0]};
        cnt_d = cnt - diff + (qm[8] ? 6'sd2 : 6'sd0);
      end else begin
        raw_d = {1'b0, qm[8], qm[7:0]};
        cnt_d = cnt + diff - (qm[8] ? 6'sd0 : 6'sd2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raw <= ctrl_code(RST_CODE_SEL);
      cnt <= '0;
    end else begin
      raw <= raw_d;
      cnt <= cnt_d;
    end
  end

endmodule

module tmds_encoder_3ch #(
  parameter logic       DVI_MODE     = 1'b1,
  parameter logic [1:0] RST_CODE_SEL = 2'b00
) (
  input  logic       PIXCLK,
  input  logic       RST,
  input  logic       DE,
  input  logic [7:0] DATAch0,
  input  logic [7:0] DATAch1,
  input  logic [7:0] DATAch2,
  input  logic       HSYNC,
  input  logic       VSYNC,
  input  logic [3:0] CTL,
  output logic [9:0] RAWDATAch0,
  output logic [9:0] RAWDATAch1,
  output logic [9:0] RAWDATAch2,
  output logic       DEout
);

  logic       de_s1;
  logic [1:0] ctl1;
  logic [1:0] ctl2;

  assign ctl1 = DVI_MODE ? 2'b00 : CTL[1:0];
  assign ctl2 = DVI_MODE ? 2'b00 : CTL[3:2];

  always_ff @(posedge PIXCLK) begin
    if (RST) begin
      de_s1 <= 1'b0;
      DEout <= 1'b0;
    end else begin
      de_s1 <= DE;
      DEout <= de_s1;
    end
  end

  tmds_encoder_3ch_lane #(.RST_CODE_SEL(RST_CODE_SEL)) u_ch0 (
    .clk(PIXCLK), .rst(RST), .de_s1(de_s1), .data(DATAch0),
    .ctrl({VSYNC, HSYNC}), .raw(RAWDATAch0)
  );

  tmds_encoder_3ch_lane #(.RST_CODE_SEL(RST_CODE_SEL)) u_ch1 (
    .clk(PIXCLK), .rst(RST), .de_s1(de_s1), .data(DATAch1),
    .ctrl(ctl1), .raw(RAWDATAch1)
  );

  tmds_encoder_3ch_lane #(.RST_CODE_SEL(RST_CODE_SEL)) u_ch2 (
    .clk(PIXCLK), .rst(RST), .de_s1(de_s1), .data(DATAch2),
    .ctrl(ctl2), .raw(RAWDATAch2)
  );

endmodule
